// File: rtl/bcd_serial_addsub_pkg.sv
// Shared constants, FSM state type and digit helpers for the digit-serial BCD adder/subtractor.
package bcd_pkg;

  localparam int         DIGIT_W  = 4;
  localparam logic [3:0] BCD_NINE = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    FIX   = 2'd2,
    FIN   = 2'd3
  } state_e;

  function automatic logic [DIGIT_W-1:0] nines_comp(input logic [DIGIT_W-1:0] digit);
    return BCD_NINE - digit;
  endfunction

endpackage

// File: rtl/bcd_serial_addsub_if.sv
// Operand/result/handshake bundle for bcd_serial_addsub; err exists only when BCD_CHECK_EN is defined.
interface bcd_serial_addsub_if #(parameter int DIGITS = 3);

  logic                  start;
  logic                  mode;
  logic                  a_sign;
  logic                  b_sign;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic [4*DIGITS-1:0]   out;
  logic                  sign;
  logic                  cout;
  logic                  busy;
  logic                  done;
`ifdef BCD_CHECK_EN
  logic                  err;
`endif

  modport master (
    output start, mode, a_sign, b_sign, a, b,
    input  out, sign, cout, busy, done
`ifdef BCD_CHECK_EN
    , input err
`endif
  );

  modport slave (
    input  start, mode, a_sign, b_sign, a, b,
    output out, sign, cout, busy, done
`ifdef BCD_CHECK_EN
    , output err
`endif
  );

endinterface

// File: rtl/bcd_serial_addsub_digit_adder.sv
// Combinational single-digit BCD adder with +6 decimal correction.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] x_i,
  input  logic [DIGIT_W-1:0] y_i,
  input  logic               c_i,
  output logic [DIGIT_W-1:0] s_o,
  output logic               c_o
);

  logic [DIGIT_W:0] raw_s;
  logic [DIGIT_W:0] corr_s;

  always_comb begin
    raw_s  = {1'b0, x_i} + {1'b0, y_i} + {{DIGIT_W{1'b0}}, c_i};
    corr_s = raw_s + 5'd6;
    if (raw_s > 5'd9) begin
      s_o = corr_s[DIGIT_W-1:0];
      c_o = 1'b1;
    end else begin
      s_o = raw_s[DIGIT_W-1:0];
      c_o = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial sign-magnitude BCD add/subtract, LSD first, with optional recomplement pass.
// Optional input digit checking is enabled by defining BCD_CHECK_EN.
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_serial_addsub_if.slave   bus
);

  localparam int W     = DIGIT_W * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e             state_q, state_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d, r_q, r_d, out_q, out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               sub_q, sub_d;
  logic               asign_q, asign_d;
  logic               eb_q, eb_d;
  logic               pend_sign_q, pend_sign_d;
  logic               pend_cout_q, pend_cout_d;
  logic               sign_q, sign_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef BCD_CHECK_EN
  logic               bad_q, bad_d;
  logic               err_q, err_d;
  logic               bad_in_s;
`endif

  logic [DIGIT_W-1:0] x_s, y_s, sum_s;
  logic               co_s;
  logic               last_s;
  logic               eb_in_s;

  assign last_s  = (cnt_q == CNT_W'(DIGITS - 1));
  assign eb_in_s = bus.b_sign ^ bus.mode;

  // FIX reuses the shared adder: (9 - R_i) + 0 + carry.
  always_comb begin
    if (state_q == FIX) begin
      x_s = nines_comp(r_q[DIGIT_W-1:0]);
      y_s = 4'd0;
    end else begin
      x_s = a_q[DIGIT_W-1:0];
      y_s = sub_q ? nines_comp(b_q[DIGIT_W-1:0]) : b_q[DIGIT_W-1:0];
    end
  end

  bcd_digit_adder u_digit_adder (
    .x_i (x_s),
    .y_i (y_s),
    .c_i (carry_q),
    .s_o (sum_s),
    .c_o (co_s)
  );

`ifdef BCD_CHECK_EN
  always_comb begin
    bad_in_s = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bad_in_s = bad_in_s | (bus.a[DIGIT_W*i +: DIGIT_W] > BCD_NINE)
                          | (bus.b[DIGIT_W*i +: DIGIT_W] > BCD_NINE);
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    r_d         = r_q;
    out_d       = out_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    sub_d       = sub_q;
    asign_d     = asign_q;
    eb_d        = eb_q;
    pend_sign_d = pend_sign_q;
    pend_cout_d = pend_cout_q;
    sign_d      = sign_q;
    cout_d      = cout_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef BCD_CHECK_EN
    bad_d       = bad_q;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          r_d     = '0;
          asign_d = bus.a_sign;
          eb_d    = eb_in_s;
          sub_d   = bus.a_sign ^ eb_in_s;
          carry_d = bus.a_sign ^ eb_in_s;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = PASS1;
`ifdef BCD_CHECK_EN
          bad_d   = bad_in_s;
          err_d   = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      PASS1: begin
        r_d     = W'({sum_s, r_q} >> DIGIT_W);
        a_d     = a_q >> DIGIT_W;
        b_d     = b_q >> DIGIT_W;
        carry_d = co_s;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_s) begin
          cnt_d = '0;
          // No final carry on a subtract means |A| < |B|: the result is a 10's complement.
          if (sub_q && !co_s) begin
            state_d     = FIX;
            carry_d     = 1'b1;
            pend_sign_d = eb_q;
            pend_cout_d = 1'b0;
          end else begin
            state_d     = FIN;
            pend_sign_d = asign_q;
            pend_cout_d = sub_q ? 1'b0 : co_s;
          end
        end else begin
          state_d = PASS1;
        end
      end
      FIX: begin
        r_d     = W'({sum_s, r_q} >> DIGIT_W);
        carry_d = co_s;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_s) begin
          cnt_d   = '0;
          state_d = FIN;
        end else begin
          state_d = FIX;
        end
      end
      FIN: begin
        out_d   = r_q;
        cout_d  = pend_cout_q;
        sign_d  = ((r_q == '0) && !pend_cout_q) ? 1'b0 : pend_sign_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
`ifdef BCD_CHECK_EN
        err_d   = bad_q;
`endif
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      out_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      asign_q     <= 1'b0;
      eb_q        <= 1'b0;
      pend_sign_q <= 1'b0;
      pend_cout_q <= 1'b0;
      sign_q      <= 1'b0;
      cout_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef BCD_CHECK_EN
      bad_q       <= 1'b0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      r_q         <= r_d;
      out_q       <= out_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      sub_q       <= sub_d;
      asign_q     <= asign_d;
      eb_q        <= eb_d;
      pend_sign_q <= pend_sign_d;
      pend_cout_q <= pend_cout_d;
      sign_q      <= sign_d;
      cout_q      <= cout_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef BCD_CHECK_EN
      bad_q       <= bad_d;
      err_q       <= err_d;
`endif
    end
  end

  assign bus.out  = out_q;
  assign bus.sign = sign_q;
  assign bus.cout = cout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
`ifdef BCD_CHECK_EN
  assign bus.err  = err_q;
`endif

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Self-checking bench for bcd_serial_addsub (3- and 6-digit instances) against a decimal arithmetic model.
module tb_bcd_serial_addsub;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bcd_serial_addsub_if #(.DIGITS(3)) bif3 ();
  bcd_serial_addsub_if #(.DIGITS(6)) bif6 ();

  bcd_serial_addsub #(.DIGITS(3)) dut3 (.clk(clk), .rst(rst), .bus(bif3));
  bcd_serial_addsub #(.DIGITS(6)) dut6 (.clk(clk), .rst(rst), .bus(bif6));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] int2bcd(input int v);
    logic [23:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Signed decimal reference: result = (+/-A) + (+/-B), magnitude wraps at 10^n.
  task automatic model(input int av, input int bv, input bit as, input bit eb, input int n,
                       output int out_v, output int sgn, output int co, output int lat);
    int lim, sa, sb, v, m;
    lim   = 10 ** n;
    sa    = as ? -av : av;
    sb    = eb ? -bv : bv;
    v     = sa + sb;
    m     = (v < 0) ? -v : v;
    co    = (m >= lim) ? 1 : 0;
    out_v = m % lim;
    sgn   = (out_v == 0 && co == 0) ? 0 : ((v < 0) ? 1 : 0);
    lat   = (as != eb && av < bv) ? 2 * n + 1 : n + 1;
  endtask

  task automatic run3(input int av, input int bv, input bit as, input bit bs, input bit md,
                      input bit glitch);
    int eo, es, ec, el, cyc;
    logic [23:0] tmp;
    model(av, bv, as, bs ^ md, 3, eo, es, ec, el);
    tmp = int2bcd(av); bif3.a = tmp[11:0];
    tmp = int2bcd(bv); bif3.b = tmp[11:0];
    bif3.a_sign = as; bif3.b_sign = bs; bif3.mode = md;
    bif3.start = 1'b1;
    @(posedge clk); #1;
    bif3.start = 1'b0;
    chk("busy_after_start", 32'(bif3.busy), 32'd1);
    cyc = 0;
    while (bif3.done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (glitch && cyc == 1) begin
        bif3.start = 1'b1;
        bif3.a = 12'h999;
      end else if (glitch && cyc == 2) begin
        bif3.start = 1'b0;
      end
    end
    tmp = int2bcd(eo);
    chk("latency", 32'(cyc), 32'(el));
    chk("out", 32'(bif3.out), 32'(tmp[11:0]));
    chk("sign", 32'(bif3.sign), 32'(es));
    chk("cout", 32'(bif3.cout), 32'(ec));
    chk("busy_at_done", 32'(bif3.busy), 32'd0);
`ifdef BCD_CHECK_EN
    chk("err_clean", 32'(bif3.err), 32'd0);
`endif
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(bif3.done), 32'd0);
  endtask

  task automatic run6(input int av, input int bv, input bit as, input bit bs, input bit md);
    int eo, es, ec, el, cyc;
    logic [23:0] tmp;
    model(av, bv, as, bs ^ md, 6, eo, es, ec, el);
    bif6.a = int2bcd(av); bif6.b = int2bcd(bv);
    bif6.a_sign = as; bif6.b_sign = bs; bif6.mode = md;
    bif6.start = 1'b1;
    @(posedge clk); #1;
    bif6.start = 1'b0;
    cyc = 0;
    while (bif6.done !== 1'b1 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    tmp = int2bcd(eo);
    chk("d6_latency", 32'(cyc), 32'(el));
    chk("d6_out", 32'(bif6.out), 32'(tmp));
    chk("d6_sign", 32'(bif6.sign), 32'(es));
    chk("d6_cout", 32'(bif6.cout), 32'(ec));
    @(posedge clk); #1;
  endtask

  initial begin
    bit saw_done;
    int cyc;
    rst = 1'b1;
    bif3.start = 1'b0; bif3.mode = 1'b0; bif3.a_sign = 1'b0; bif3.b_sign = 1'b0;
    bif3.a = '0; bif3.b = '0;
    bif6.start = 1'b0; bif6.mode = 1'b0; bif6.a_sign = 1'b0; bif6.b_sign = 1'b0;
    bif6.a = '0; bif6.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 32'(bif3.out), 32'd0);
    chk("rst_sign", 32'(bif3.sign), 32'd0);
    chk("rst_cout", 32'(bif3.cout), 32'd0);
    chk("rst_busy", 32'(bif3.busy), 32'd0);
    chk("rst_done", 32'(bif3.done), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run3(348, 786, 1'b0, 1'b0, 1'b0, 1'b0);
    run3(348, 786, 1'b1, 1'b0, 1'b0, 1'b0);
    run3(348, 786, 1'b0, 1'b1, 1'b0, 1'b0);
    run3(348, 786, 1'b1, 1'b1, 1'b0, 1'b0);
    run3(500, 500, 1'b0, 1'b0, 1'b1, 1'b0);
    run3(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    run3(999, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    run3(1, 999, 1'b0, 1'b0, 1'b1, 1'b0);
    run3(123, 456, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int k = 0; k < 16; k++) begin
      run3(int'($urandom_range(0, 999)), int'($urandom_range(0, 999)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    // Abort mid-operation: reset must clear the held result and suppress done.
    run3(321, 111, 1'b0, 1'b0, 1'b0, 1'b0);
    bif3.a = 12'h777; bif3.b = 12'h111; bif3.mode = 1'b0;
    bif3.start = 1'b1;
    @(posedge clk); #1;
    bif3.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 32'(bif3.busy), 32'd0);
    chk("abort_out", 32'(bif3.out), 32'd0);
    chk("abort_done", 32'(bif3.done), 32'd0);
    saw_done = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bif3.done === 1'b1) saw_done = 1'b1;
    end
    chk("abort_no_done", 32'(saw_done), 32'd0);
    run3(250, 125, 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef BCD_CHECK_EN
    bif3.a = 12'h3A8; bif3.b = 12'h000; bif3.mode = 1'b0;
    bif3.a_sign = 1'b0; bif3.b_sign = 1'b0;
    bif3.start = 1'b1;
    @(posedge clk); #1;
    bif3.start = 1'b0;
    cyc = 0;
    while (bif3.done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("err_done_seen", 32'(bif3.done), 32'd1);
    chk("err_set", 32'(bif3.err), 32'd1);
    @(posedge clk); #1;
    run3(123, 1, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    run6(999999, 1, 1'b0, 1'b0, 1'b0);
    run6(123456, 654321, 1'b0, 1'b0, 1'b1);
    run6(int'($urandom_range(0, 999999)), int'($urandom_range(0, 999999)),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_serial_addsub.md
Name: bcd_serial_addsub

Overview:
- Parametrised, digit-serial, sign-magnitude BCD adder/subtractor. Processes one BCD digit per clock, least significant digit first.
- Successor to the 3-digit combinational Integer3digitsAddSub: digit count is generic and a start/busy/done handshake is added.
- Sits between operand registers and the display/result path of the basic calculator.

Parameters:
- DIGITS, 3, number of BCD digits per operand and per result (width = 4*DIGITS).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; sampled only while busy=0
- mode  input  1  0=add, 1=subtract (A - B)
- a_sign  input  1  sign of A (1=negative)
- b_sign  input  1  sign of B (1=negative)
- a  input  4*DIGITS  magnitude of A, BCD
- b  input  4*DIGITS  magnitude of B, BCD
- out  output  4*DIGITS  result magnitude, BCD
- sign  output  1  result sign
- cout  output  1  decimal overflow (carry out of top digit)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when out/sign/cout are valid

Behaviour:
- Reset (sync, rst=1 at a clk edge): state=IDLE; out=0, sign=0, cout=0, busy=0, done=0. Reset during an operation aborts it; done is not pulsed.
- Start:
  - On start=1 with busy=0, latch a, b, a_sign, and eb = b_sign^mode; busy=1 on the next cycle.
  - start while busy=1 is ignored.
  - start and rst together: rst wins.
- Effective operation: add if a_sign==eb, else subtract.
- States: IDLE -> PASS1 -> (FIX) -> FIN -> IDLE.
- PASS1 (DIGITS cycles), digit index i = 0..DIGITS-1:
  - Add: digit_i = A_i + B_i + c, with +6 correction when the raw sum > 9.
  - Subtract: digit_i = A_i + (9 - B_i) + c, with the same correction; initial c=1 (10's complement).
- End of PASS1:
  - Add: cout = final carry; sign = a_sign; go to FIN.
  - Subtract with final carry = 1 (|A| >= |B|): cout=0; sign = a_sign; go to FIN.
  - Subtract with final carry = 0 (|A| < |B|): go to FIX.
- FIX (DIGITS cycles): recomplement the result. digit_i = (9 - R_i) + c with c0=1, BCD corrected; sign = eb; cout=0.
- Zero-result rule: if magnitude == 0 and cout == 0, sign is forced to 0 (no negative zero).
- FIN (1 cycle): commit out/sign/cout; done=1; busy=0 on the following cycle.
- Latency from the start edge to done:
  - DIGITS+1 cycles without recomplement.
  - 2*DIGITS+1 cycles with recomplement.
- Output hold: out, sign and cout hold their values until the next FIN commit or reset.
- A new start is accepted the cycle after done.
- Non-BCD input digits (>9) produce an undefined magnitude, but the state machine and latency are unaffected.

Optional Feature:
- Macro: BCD_CHECK_EN.
- Defined:
  - Adds output port err (1 bit), reset 0.
  - On start, if any latched digit of a or b is > 9, err=1, committed together with done.
  - err clears at the next accepted start.
- Undefined: no err port, no checking logic.

Decomposition:
- Package bcd_pkg:
  - DIGIT_W=4 and BCD_NINE=4'd9 constants.
  - State enum {IDLE, PASS1, FIX, FIN}.
  - Function nines_comp(digit).
- Sub-module bcd_digit_adder: combinational one-digit BCD add. Inputs: 4-bit x, 4-bit y, carry in. Outputs: corrected 4-bit sum, carry out. Instantiated once and shared by PASS1 and FIX.
- Top level: shift registers, digit counter and FSM.

Test Plan:
- DIGITS=3; A=348, B=786, mode=0, a_sign=0, b_sign=0 -> out=134, cout=1, sign=0; done at start+4.
- Same operands, a_sign=1, b_sign=0 -> out=438, sign=0, cout=0; done at start+7 (FIX pass taken).
- Same operands, a_sign=0, b_sign=1 -> out=438, sign=1, cout=0; done at start+7. Then both signs 1 -> out=134, sign=1, cout=1.
- A=500, B=500, mode=1, signs 0 -> out=000, sign=0, cout=0; done at start+4. Also A=0, B=0, a_sign=1, mode=0 -> sign=0.
- Second start pulsed while busy -> ignored, first result unchanged. rst asserted at start+2 -> busy=0 and out=0 next cycle, no done. A new start afterwards completes normally.
- BCD_CHECK_EN defined, A=0x3A8 -> err=1 with done; next valid start -> err=0. Also DIGITS=6 regression: 999999+1 -> out=000000, cout=1.
